// File: rtl/gf180mcu_fd_sc_mcu9t5v0__xnorn_pipe.sv
// Pipelined, multi-lane N-input XOR/XNOR reduction with packet accumulation.
// Each lane reduces WIDTH bits to one parity bit. Results travel through a
// LAT-stage elastic pipeline with valid/ready handshakes on both sides.
// In accumulate mode, parity is carried across beats. One result per packet
// is emitted, on the LAST beat.
module gf180mcu_fd_sc_mcu9t5v0__xnorn_pipe #(
  parameter int WIDTH = 9,
  parameter int LANES = 2,
  parameter int LAT   = 2,
  parameter int CNTW  = 4
) (
  input  logic                   CLK,
  input  logic                   RN,
  inout  wire                    VDD,
  inout  wire                    VSS,
  input  logic [WIDTH*LANES-1:0] A,
  input  logic [1:0]             MODE,
  input  logic                   LAST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  output logic [LANES-1:0]       ZN,
  output logic [CNTW-1:0]        CNT,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Supply pins exist only for netlist compatibility with the cell library.
  wire unused_power = VDD ^ VSS;

  // Per-lane parity of the incoming beat.
  logic [LANES-1:0] red;
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : gen_lane
      assign red[gi] = ^A[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Packet state: running parity and saturating beat counter.
  logic [LANES-1:0] acc_q, acc_d;
  logic [CNTW-1:0]  bcnt_q, bcnt_d;
  logic [CNTW-1:0]  cnt_inc;

  // Pipeline stage storage. Index 0 is fed from the input; LAT-1 drives outputs.
  logic             stage_v_q   [LAT];
  logic [LANES-1:0] stage_zn_q  [LAT];
  logic [CNTW-1:0]  stage_cnt_q [LAT];
  logic [LAT-1:0]   stage_ld;   // stage may take new contents this cycle
  logic [LAT-1:0]   stage_adv;  // stage contents move on this cycle

  logic             accept;
  logic             push;
  logic [LANES-1:0] push_zn;
  logic [CNTW-1:0]  push_cnt;

  // Ready chain, walked from the output back to the input so each stage sees its successor.
  always_comb begin
    stage_ld  = '0;
    stage_adv = '0;
    for (int i = LAT - 1; i >= 0; i--) begin
      if (i == LAT - 1) begin
        stage_adv[i] = stage_v_q[i] && OUT_READY;
      end else begin
        stage_adv[i] = stage_v_q[i] && stage_ld[i+1];
      end
      stage_ld[i] = !stage_v_q[i] || stage_adv[i];
    end
  end

  assign IN_READY = RN && stage_ld[0];
  assign accept   = IN_VALID && IN_READY;
  assign cnt_inc  = (bcnt_q == CNT_MAX) ? CNT_MAX : bcnt_q + CNTW'(1);

  // Decide what an accepted beat does to the packet state and what it pushes.
  always_comb begin
    acc_d    = acc_q;
    bcnt_d   = bcnt_q;
    push     = 1'b0;
    push_zn  = red ^ {LANES{MODE[0]}};
    push_cnt = CNTW'(1);
    if (accept) begin
      if (!MODE[1]) begin
        push = 1'b1;
      end else if (LAST) begin
        push     = 1'b1;
        push_zn  = acc_q ^ red ^ {LANES{MODE[0]}};
        push_cnt = cnt_inc;
        acc_d    = '0;
        bcnt_d   = '0;
      end else begin
        acc_d  = acc_q ^ red;
        bcnt_d = cnt_inc;
      end
    end
  end

  // Packet accumulator and beat counter registers.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      acc_q  <= '0;
      bcnt_q <= '0;
    end else begin
      acc_q  <= acc_d;
      bcnt_q <= bcnt_d;
    end
  end

  // Elastic pipeline; data regs only load with valid contents so outputs hold.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      for (int i = 0; i < LAT; i++) begin
        stage_v_q[i]   <= 1'b0;
        stage_zn_q[i]  <= '0;
        stage_cnt_q[i] <= '0;
      end
    end else begin
      if (stage_ld[0]) begin
        stage_v_q[0] <= push;
        if (push) begin
          stage_zn_q[0]  <= push_zn;
          stage_cnt_q[0] <= push_cnt;
        end
      end
      for (int i = 1; i < LAT; i++) begin
        if (stage_ld[i]) begin
          stage_v_q[i] <= stage_v_q[i-1];
          if (stage_v_q[i-1]) begin
            stage_zn_q[i]  <= stage_zn_q[i-1];
            stage_cnt_q[i] <= stage_cnt_q[i-1];
          end
        end
      end
    end
  end

  assign OUT_VALID = stage_v_q[LAT-1];
  assign ZN        = stage_zn_q[LAT-1];
  assign CNT       = stage_cnt_q[LAT-1];

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__xnorn_pipe.md
Name: gf180mcu_fd_sc_mcu9t5v0__xnorn_pipe

Overview:
- Parametrised, pipelined successor to the 3-input XNOR cell.
- Per-lane N-input XOR/XNOR reduction over LANES independent lanes, with a LAT-stage elastic pipeline and valid/ready handshake on both sides.
- Accumulate mode: a running parity is carried across beats and one result is emitted per packet, on the LAST beat.
- Sits in datapath parity/ECC-check logic built from library cells; it is the registered, multi-lane replacement for chained xnor3 instances.

Parameters:
- WIDTH, 9, data inputs reduced per lane (>=2).
- LANES, 2, independent reduction lanes (>=1).
- LAT, 2, register stages from input acceptance to output (1..4).
- CNTW, 4, width of the per-packet beat counter (>=1).

Ports:
- CLK  input  1  rising-edge clock.
- RN  input  1  synchronous active-low reset.
- VDD  inout  1  power.
- VSS  inout  1  ground.
- A  input  WIDTH*LANES  lane k occupies A[k*WIDTH +: WIDTH].
- MODE  input  2  bit0 = invert (XNOR), bit1 = accumulate; sampled per accepted beat.
- LAST  input  1  final beat of a packet; only meaningful when MODE[1]=1.
- IN_VALID  input  1  input beat valid.
- IN_READY  output  1  block can accept a beat.
- ZN  output  LANES  per-lane result.
- CNT  output  CNTW  beats in the packet, saturating.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts the result.

Behaviour:
- One clock, CLK. Reset is synchronous and active-low on RN.
- Reset state, sampled at a CLK edge with RN=0:
  - all stage valid bits, ZN, CNT, per-lane accumulators and the beat counter clear to 0.
  - OUT_VALID=0.
  - IN_READY is forced 0 while RN=0.
  - Reset mid-operation discards all in-flight beats and any partial packet.
- Handshakes:
  - Input beat accepted when IN_VALID && IN_READY.
  - Output beat consumed when OUT_VALID && OUT_READY.
  - OUT_VALID, ZN and CNT hold stable until consumed.
- Reduction: r[k] = XOR of all WIDTH bits of lane k.
- Non-accumulate beat (MODE[1]=0):
  - pushes ZN[k] = r[k] ^ MODE[0] and CNT = 1.
  - accumulators and the beat counter are unchanged. LAST is ignored.
- Accumulate beat (MODE[1]=1, LAST=0):
  - acc[k] <= acc[k] ^ r[k]; beat counter increments, saturating at 2^CNTW-1.
  - nothing is pushed into the pipeline.
- Accumulate beat (MODE[1]=1, LAST=1):
  - pushes ZN[k] = acc[k] ^ r[k] ^ MODE[0], and CNT = counter+1 saturated.
  - acc and the counter clear to 0 in the same cycle.
- A non-accumulate beat in the middle of a packet is emitted normally and does not disturb acc or the counter.
- Pipeline:
  - LAT stages, each with a valid bit.
  - A stage loads when it is empty or its contents move on in the same cycle.
  - IN_READY = !stage0_valid || stage0_advances. This is a combinational ready chain from OUT_READY.
  - Accumulate non-LAST beats are also gated by IN_READY; no bubble rule differs.
- Latency and throughput:
  - With OUT_READY held at 1, a pushing beat accepted at edge t shows OUT_VALID=1 after edge t+LAT-1, i.e. LAT cycles from acceptance.
  - Sustained throughput is 1 beat/cycle.
- Full pipeline with OUT_READY=0: IN_READY=0 and no data is lost or duplicated.
- Simultaneous pop at the output and push at the input while full is allowed: IN_READY=1 in that cycle.
- Counter saturation: CNT stays at 2^CNTW-1 for longer packets. The parity result is still exact.

Test Plan:
- Reset and idle: hold RN=0 for 3 cycles with IN_VALID=1 -> IN_READY=0, OUT_VALID=0, ZN=0, CNT=0. After release, IN_READY=1 on the first cycle.
- XNOR single beat (LAT=2): A lane0=9'h1FF, lane1=9'h003, MODE=01, OUT_READY=1 -> OUT_VALID after 2 cycles, ZN=2'b10, CNT=1. Same data with MODE=00 -> ZN=2'b01.
- Accumulate packet: beats lane0 = 9'h001, 9'h001, 9'h001 (LAST on 3rd), lane1 = 0, MODE=10 -> exactly one output, ZN=2'b01, CNT=3. Repeat with MODE=11 -> ZN=2'b10.
- Backpressure: stream 6 XOR beats with OUT_READY=0 -> IN_READY falls after LAT accepts. Release OUT_READY -> all 6 results emerge in order, unchanged, none dropped.
- Saturation (CNTW=4): 20-beat accumulate packet, lane0 bits set on 7 beats -> CNT=15, ZN[0]=1.
- Reset mid-packet: 2 accumulate beats, then RN=0 for 1 cycle, then a 1-beat packet with A lane0=9'h001, LAST=1, MODE=10 -> ZN[0]=1, CNT=1, showing no residue from before reset.
